rr_mux4_arbiter: RTL



---
 rtl/rr_mux4_arbiter_if.sv | 10 +
 rtl/rr_mux4_arbiter.sv | 61 ++++++
 2 files changed

// File: rtl/rr_mux4_arbiter_if.sv
// rr_mux4_arbiter_if: request/data/grant bundle; slave=arbiter (req,A..D in; gnt,s1,s0,busy,out1 out), master=requesters
interface rr_mux4_arbiter_if;
  logic [3:0] req;
  logic a_unused_guard;
  logic A, B, C, D;
  logic [3:0] gnt;
  logic s1, s0, busy, out1;
  modport slave (input req, A, B, C, D, output gnt, s1, s0, busy, out1);
  modport master (output req, A, B, C, D, input gnt, s1, s0, busy, out1);
endinterface

// File: rtl/rr_mux4_arbiter.sv
// rr_mux4_arbiter: round-robin 4:1 mux arbiter with bounded hold; ports clk, rst_n, bus (req,A..D in; gnt,s1,s0,busy,out1 out)
module rr_mux4_arbiter #(
  parameter int MAX_HOLD = 4,
  parameter int CW = 4
) (
  input logic clk,
  input logic rst_n,
  rr_mux4_arbiter_if.slave bus
);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state, state_n;
  logic [1:0] sel, sel_n, last, last_n, base, win;
  logic [CW-1:0] cnt, cnt_n;
  logic [3:0] dat;
  logic any, rel;
  assign any = |bus.req;
  assign dat = {bus.D, bus.C, bus.B, bus.A};
  // search starts after the most recent owner, which ends up lowest priority
  assign base = (state == GRANT) ? sel : last;
  always_comb begin
    win = base;
    for (int i = 4; i >= 1; i--)
      if (bus.req[2'(base + 2'(i))]) win = 2'(base + 2'(i));
  end
  assign rel = !bus.req[sel] || cnt == CW'(MAX_HOLD - 1);
  always_comb begin
    state_n = state;
    sel_n = sel;
    last_n = last;
    cnt_n = cnt;
    if (state == IDLE) begin
      if (any) begin
        state_n = GRANT;
        sel_n = win;
        cnt_n = '0;
      end
    end else if (rel) begin
      last_n = sel;
      state_n = any ? GRANT : IDLE;
      sel_n = any ? win : sel;
      cnt_n = '0;
    end else cnt_n = cnt + 1'b1;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      sel <= 2'd0;
      last <= 2'd3;
      cnt <= '0;
    end else begin
      state <= state_n;
      sel <= sel_n;
      last <= last_n;
      cnt <= cnt_n;
    end
  assign bus.busy = state == GRANT;
  assign bus.gnt = bus.busy ? 4'b0001 << sel : 4'b0000;
  assign bus.s1 = sel[1];
  assign bus.s0 = sel[0];
  assign bus.out1 = bus.busy & dat[sel];
endmodule
